// File: rtl/db15_joy_tx.sv
// db15_joy_tx: device side of the SNAC DB15 serial joystick link, emulating a 74HC165-style pad chain.
// Optional macro DB15_GLITCH_FILTER_EN inserts a FILT_LEN-cycle stability filter after the synchronisers.
module db15_joy_tx #(
  parameter int PBITS    = 12,
  parameter int FILT_LEN = 3
) (
  input  logic             clk_53p6,
  input  logic             reset,
  input  logic [PBITS-1:0] player1,
  input  logic [PBITS-1:0] player2,
  input  logic             joy_load_in,
  input  logic             joy_clk_in,
  output logic             joy_data_out,
  output logic             frame_done,
  output logic [4:0]       bit_cnt
);
  localparam int FW = 2 * PBITS;
  localparam logic [4:0] LAST = 5'(FW);

  if (FILT_LEN < 1 || FW > 31) begin : g_bad_param
    $error("db15_joy_tx: FILT_LEN must be >= 1 and 2*PBITS must fit bit_cnt");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state, state_n;
  logic [FW-1:0] sreg, sreg_n;
  logic [FW-1:0] frame;
  logic [4:0]    cnt_n;
  logic          data_n, done_n;
  logic          load_p0, load_p1, clk_p0, clk_p1;
  logic          load_lvl, clk_lvl, clk_dly, clk_rise;

  // p0/p1: two-flop synchronisers, preset high so reset never looks like a load or an edge
  always_ff @(posedge clk_53p6) begin
    if (reset) begin
      load_p0 <= 1'b1;
      load_p1 <= 1'b1;
      clk_p0  <= 1'b1;
      clk_p1  <= 1'b1;
    end else begin
      load_p0 <= joy_load_in;
      load_p1 <= load_p0;
      clk_p0  <= joy_clk_in;
      clk_p1  <= clk_p0;
    end
  end

`ifdef DB15_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0] FLAST = FCW'(FILT_LEN - 1);

  logic           load_p2, clk_p2;
  logic [FCW-1:0] load_fc, clk_fc;

  // p2: filter input sample; a level is accepted after FILT_LEN consecutive differing samples
  always_ff @(posedge clk_53p6) begin
    if (reset) begin
      load_p2  <= 1'b1;
      clk_p2   <= 1'b1;
      load_lvl <= 1'b1;
      clk_lvl  <= 1'b1;
      load_fc  <= '0;
      clk_fc   <= '0;
    end else begin
      load_p2 <= load_p1;
      clk_p2  <= clk_p1;
      if (load_p2 == load_lvl) begin
        load_fc <= '0;
      end else if (load_fc == FLAST) begin
        load_lvl <= load_p2;
        load_fc  <= '0;
      end else begin
        load_fc <= load_fc + 1'b1;
      end
      if (clk_p2 == clk_lvl) begin
        clk_fc <= '0;
      end else if (clk_fc == FLAST) begin
        clk_lvl <= clk_p2;
        clk_fc  <= '0;
      end else begin
        clk_fc <= clk_fc + 1'b1;
      end
    end
  end
`else
  assign load_lvl = load_p1;
  assign clk_lvl  = clk_p1;
`endif

  always_ff @(posedge clk_53p6) begin
    if (reset) clk_dly <= 1'b1;
    else       clk_dly <= clk_lvl;
  end

  assign clk_rise = clk_lvl & ~clk_dly;
  assign frame    = ~{player2, player1};

  // A low load wins over everything, including a same-cycle clock edge
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = bit_cnt;
    data_n  = joy_data_out;
    done_n  = 1'b0;
    if (!load_lvl) begin
      state_n = LOAD;
      sreg_n  = frame;
      cnt_n   = '0;
      data_n  = frame[0];
    end else begin
      case (state)
        IDLE:  data_n = 1'b1;
        LOAD: begin
          state_n = SHIFT;
          data_n  = sreg[0];
        end
        SHIFT: begin
          if (clk_rise) begin
            sreg_n = {1'b1, sreg[FW-1:1]};
            cnt_n  = bit_cnt + 5'd1;
            data_n = sreg[1];
            if (cnt_n == LAST) begin
              done_n  = 1'b1;
              state_n = DONE;
              data_n  = 1'b1;
            end
          end
        end
        DONE:    data_n  = 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_53p6) begin
    if (reset) begin
      state        <= IDLE;
      sreg         <= '1;
      bit_cnt      <= '0;
      joy_data_out <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      sreg         <= sreg_n;
      bit_cnt      <= cnt_n;
      joy_data_out <= data_n;
      frame_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_db15_joy_tx.sv
// Randomised self-checking bench for db15_joy_tx against a frame-level model of the serial link.
module tb_db15_joy_tx;
  localparam int PBITS = 12;
  localparam int W     = 2 * PBITS;
  localparam int HOLD  = 12;

  logic             clk_53p6 = 1'b0;
  logic             reset = 1'b1;
  logic [PBITS-1:0] player1 = '0;
  logic [PBITS-1:0] player2 = '0;
  logic             joy_load_in = 1'b1;
  logic             joy_clk_in = 1'b0;
  logic             joy_data_out, frame_done;
  logic [4:0]       bit_cnt;

  int checks = 0;
  int passed = 0;
  int fd_cnt = 0;

  db15_joy_tx #(.PBITS(PBITS), .FILT_LEN(3)) dut (
    .clk_53p6    (clk_53p6),
    .reset       (reset),
    .player1     (player1),
    .player2     (player2),
    .joy_load_in (joy_load_in),
    .joy_clk_in  (joy_clk_in),
    .joy_data_out(joy_data_out),
    .frame_done  (frame_done),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk_53p6 = ~clk_53p6;

  always @(negedge clk_53p6) if (frame_done === 1'b1) fd_cnt++;

  // Reference model: the wire carries ~{p2,p1} LSB first, then 1s once the frame is exhausted
  function automatic logic [W-1:0] model_frame(logic [PBITS-1:0] p1, logic [PBITS-1:0] p2);
    return ~{p2, p1};
  endfunction

  function automatic logic model_bit(logic [W-1:0] f, int n);
    return (n >= W) ? 1'b1 : f[n];
  endfunction

  function automatic logic [4:0] model_cnt(int n);
    return 5'((n > W) ? W : n);
  endfunction

  task automatic cycles(int n);
    repeat (n) @(posedge clk_53p6);
    #1;
  endtask

  task automatic do_load(logic [PBITS-1:0] p1, logic [PBITS-1:0] p2);
    player1 = p1;
    player2 = p2;
    joy_load_in = 1'b0;
    cycles(HOLD);
    joy_load_in = 1'b1;
    cycles(HOLD);
  endtask

  task automatic clk_pulse(int hi, int lo);
    joy_clk_in = 1'b1;
    cycles(hi);
    joy_clk_in = 1'b0;
    cycles(lo);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_53p6);
      #1;
      player1 = PBITS'($urandom);
      player2 = PBITS'($urandom);
      joy_load_in = 1'($urandom);
      joy_clk_in = 1'($urandom);
      checks++;
      if (joy_data_out !== 1'b1) $display("FAIL reset_data cyc %0d: got %b want 1", i, joy_data_out);
      else passed++;
      checks++;
      if (bit_cnt !== 5'd0) $display("FAIL reset_cnt cyc %0d: got %0d want 0", i, bit_cnt);
      else passed++;
      checks++;
      if (frame_done !== 1'b0) $display("FAIL reset_done cyc %0d: got %b want 0", i, frame_done);
      else passed++;
    end
    joy_load_in = 1'b1;
    joy_clk_in = 1'b0;
    reset = 1'b0;
    cycles(HOLD);
    checks++;
    if (joy_data_out !== 1'b1 || bit_cnt !== 5'd0)
      $display("FAIL idle_after_reset: got data %b cnt %0d want 1/0", joy_data_out, bit_cnt);
    else passed++;
  endtask

  task automatic test_full_frame;
    int fd0;
    logic want;
    player1 = 12'h001;
    player2 = 12'h800;
    joy_load_in = 1'b0;
    cycles(20);
    checks++;
    if (joy_data_out !== 1'b0 || bit_cnt !== 5'd0)
      $display("FAIL full_load: got data %b cnt %0d want 0/0", joy_data_out, bit_cnt);
    else passed++;
    joy_load_in = 1'b1;
    cycles(20);
    fd0 = fd_cnt;
    for (int e = 1; e <= W + 2; e++) begin
      clk_pulse(20, 20);
      want = (e == 23) ? 1'b0 : 1'b1;
      checks++;
      if (joy_data_out !== want) $display("FAIL full_bit e%0d: got %b want %b", e, joy_data_out, want);
      else passed++;
      checks++;
      if (bit_cnt !== model_cnt(e)) $display("FAIL full_cnt e%0d: got %0d want %0d", e, bit_cnt, model_cnt(e));
      else passed++;
      checks++;
      if (fd_cnt - fd0 !== ((e >= W) ? 1 : 0))
        $display("FAIL full_done e%0d: got %0d pulses want %0d", e, fd_cnt - fd0, (e >= W) ? 1 : 0);
      else passed++;
    end
  endtask

  task automatic test_random_frames;
    logic [PBITS-1:0] p1, p2;
    logic [W-1:0] f;
    int fd0;
    for (int it = 0; it < 4; it++) begin
      p1 = PBITS'($urandom);
      p2 = PBITS'($urandom);
      f = model_frame(p1, p2);
      do_load(p1, p2);
      fd0 = fd_cnt;
      checks++;
      if (joy_data_out !== f[0]) $display("FAIL rnd_first it%0d: got %b want %b", it, joy_data_out, f[0]);
      else passed++;
      for (int e = 1; e <= W + 1; e++) begin
        clk_pulse(HOLD, HOLD);
        checks++;
        if (joy_data_out !== model_bit(f, e) || bit_cnt !== model_cnt(e))
          $display("FAIL rnd_bit it%0d e%0d: got %b/%0d want %b/%0d", it, e, joy_data_out, bit_cnt,
                   model_bit(f, e), model_cnt(e));
        else passed++;
      end
      checks++;
      if (fd_cnt - fd0 !== 1) $display("FAIL rnd_done it%0d: got %0d pulses want 1", it, fd_cnt - fd0);
      else passed++;
    end
  endtask

  task automatic test_load_priority;
    logic [PBITS-1:0] p1, p2;
    logic [W-1:0] f;
    int fd0;
    p1 = PBITS'($urandom);
    p2 = PBITS'($urandom);
    f = model_frame(p1, p2);
    do_load(p1, p2);
    fd0 = fd_cnt;
    for (int e = 0; e < 5; e++) clk_pulse(HOLD, HOLD);
    joy_load_in = 1'b0;
    joy_clk_in = 1'b1;
    cycles(HOLD);
    checks++;
    if (bit_cnt !== 5'd0) $display("FAIL prio_cnt: got %0d want 0", bit_cnt);
    else passed++;
    checks++;
    if (joy_data_out !== ~p1[0]) $display("FAIL prio_data: got %b want %b", joy_data_out, ~p1[0]);
    else passed++;
    joy_load_in = 1'b1;
    joy_clk_in = 1'b0;
    cycles(HOLD);
    clk_pulse(HOLD, HOLD);
    checks++;
    if (bit_cnt !== 5'd1 || joy_data_out !== f[1])
      $display("FAIL prio_resume: got %b/%0d want %b/1", joy_data_out, bit_cnt, f[1]);
    else passed++;
    checks++;
    if (fd_cnt !== fd0) $display("FAIL prio_nodone: got %0d pulses want 0", fd_cnt - fd0);
    else passed++;
  endtask

  task automatic test_midframe_reset;
    logic [PBITS-1:0] p1, p2;
    logic [W-1:0] f;
    int fd0;
    do_load(PBITS'($urandom), PBITS'($urandom));
    fd0 = fd_cnt;
    for (int e = 0; e < 10; e++) clk_pulse(HOLD, HOLD);
    reset = 1'b1;
    cycles(1);
    checks++;
    if (joy_data_out !== 1'b1 || bit_cnt !== 5'd0 || frame_done !== 1'b0)
      $display("FAIL mreset_state: got %b/%0d/%b want 1/0/0", joy_data_out, bit_cnt, frame_done);
    else passed++;
    cycles(1);
    reset = 1'b0;
    cycles(HOLD);
    clk_pulse(HOLD, HOLD);
    checks++;
    if (joy_data_out !== 1'b1 || bit_cnt !== 5'd0)
      $display("FAIL mreset_idle: got %b/%0d want 1/0", joy_data_out, bit_cnt);
    else passed++;
    checks++;
    if (fd_cnt !== fd0) $display("FAIL mreset_nodone: got %0d pulses want 0", fd_cnt - fd0);
    else passed++;
    p1 = PBITS'($urandom);
    p2 = PBITS'($urandom);
    f = model_frame(p1, p2);
    do_load(p1, p2);
    for (int e = 1; e <= W; e++) begin
      clk_pulse(HOLD, HOLD);
      checks++;
      if (joy_data_out !== model_bit(f, e) || bit_cnt !== model_cnt(e))
        $display("FAIL mreset_frame e%0d: got %b/%0d want %b/%0d", e, joy_data_out, bit_cnt,
                 model_bit(f, e), model_cnt(e));
      else passed++;
    end
    checks++;
    if (fd_cnt - fd0 !== 1) $display("FAIL mreset_done: got %0d pulses want 1", fd_cnt - fd0);
    else passed++;
  endtask

  task automatic test_input_freeze;
    logic [PBITS-1:0] p2;
    logic [W-1:0] f;
    p2 = PBITS'($urandom);
    f = model_frame(12'h000, p2);
    do_load(12'h000, p2);
    for (int e = 1; e <= W; e++) begin
      clk_pulse(HOLD, HOLD);
      if (e == 3) begin
        player1 = 12'hFFF;
        player2 = ~p2;
      end
      checks++;
      if (joy_data_out !== model_bit(f, e))
        $display("FAIL freeze_bit e%0d: got %b want %b", e, joy_data_out, model_bit(f, e));
      else passed++;
    end
  endtask

  task automatic test_glitch;
    int want1, want2;
`ifdef DB15_GLITCH_FILTER_EN
    want1 = 0;
`else
    want1 = 1;
`endif
    want2 = want1 + 1;
    do_load(PBITS'($urandom), PBITS'($urandom));
    clk_pulse(2, 20);
    checks++;
    if (bit_cnt !== 5'(want1)) $display("FAIL glitch_2cyc: got %0d want %0d", bit_cnt, want1);
    else passed++;
    clk_pulse(3, 20);
    checks++;
    if (bit_cnt !== 5'(want2)) $display("FAIL glitch_3cyc: got %0d want %0d", bit_cnt, want2);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_frames();
    test_load_priority();
    test_midframe_reset();
    test_input_freeze();
    test_glitch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
